// File: rtl/latch_wr_sched.sv
// Round-robin write scheduler for a shared transparent latch: grant+data registered one edge after request, OPEN_CYC+2 busy cycles.
// Requesters wait on req until ack; the data pin only moves on the grant edge and is stable whenever lat_en is high.
module latch_wr_sched #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int OPEN_CYC = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   wdata,
   output logic [N_REQ-1:0]          grant,
   output logic [N_REQ-1:0]          ack,
   output logic [DATA_W-1:0]         lat_d,
   output logic                      lat_en,
   output logic [DATA_W-1:0]         lat_q_mirror,
   output logic                      busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_OPEN  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [IW-1:0] last;
   logic [IW-1:0] win;
   logic          win_vld;

   // Search starts just after the previous winner and wraps, so every requester is reached within N_REQ grants.
   always_comb begin
      int idx;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!win_vld && req[idx]) begin
            win     = IW'(idx);
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= '0;
         last         <= IW'(N_REQ - 1);
         grant        <= '0;
         ack          <= '0;
         lat_d        <= '0;
         lat_en       <= 1'b0;
         lat_q_mirror <= '0;
         busy         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  grant      <= '0;
                  grant[win] <= 1'b1;
                  lat_d      <= wdata[int'(win)*DATA_W +: DATA_W];
                  last       <= win;
                  busy       <= 1'b1;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: begin
               lat_en <= 1'b1;
               cnt    <= 4'd1;
               state  <= S_OPEN;
            end
            S_OPEN: begin
               if (cnt == 4'(OPEN_CYC)) begin
                  // Closing the latch and acking share an edge; the mirror tracks what the latch just captured.
                  lat_en       <= 1'b0;
                  ack          <= grant;
                  lat_q_mirror <= lat_d;
                  state        <= S_HOLD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               ack   <= '0;
               grant <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
